// File: rtl/cache_assoc_pkg.sv
// cache_assoc_pkg
// Shared types and constants for the 2-way set-associative write-back cache.
//   state_t      : controller state encoding
//   REQ_READ/REQ_WRITE : encoding of the CPU req_type bit
//   NUM_WAYS     : associativity (fixed at 2; LRU is a single bit per set)
//   pick_victim  : replacement choice, first invalid way, else the LRU way
// Optional feature macro used by the top: CACHE_PERF_CNT_EN.
package cache_assoc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPARE   = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_ALLOCATE  = 3'd3,
    ST_FLUSH     = 3'd4,
    ST_FLUSH_WB  = 3'd5
  } state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;
  localparam int   NUM_WAYS  = 2;

  function automatic logic pick_victim(input logic v0, input logic v1, input logic lru);
    if (!v0)      return 1'b0;
    else if (!v1) return 1'b1;
    else          return lru;
  endfunction

endpackage

// File: rtl/cache_assoc_array.sv
// cache_assoc_array
// Tag/data/valid/dirty/LRU storage for a 2-way cache with one word per line.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears valid/dirty/LRU)
//   i_rd_idx        : lookup set index; o_tag/o_data/o_valid/o_dirty/o_lru are
//                     the combinational contents of both ways of that set
//   i_we, i_way, i_wr_idx, i_wr_tag, i_wr_data, i_wr_dirty
//                   : single entry write port; a written entry is always valid
//   i_lru_we, i_lru_val : LRU bit write for set i_wr_idx (value = way to evict next)
//   i_clr_valid     : clear every valid bit (end of flush)
module cache_assoc_array
  import cache_assoc_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [IDX_W-1:0]                 i_rd_idx,
  output logic [NUM_WAYS-1:0][TAG_W-1:0]   o_tag,
  output logic [NUM_WAYS-1:0][DATA_W-1:0]  o_data,
  output logic [NUM_WAYS-1:0]              o_valid,
  output logic [NUM_WAYS-1:0]              o_dirty,
  output logic                             o_lru,
  input  logic                             i_we,
  input  logic                             i_way,
  input  logic [IDX_W-1:0]                 i_wr_idx,
  input  logic [TAG_W-1:0]                 i_wr_tag,
  input  logic [DATA_W-1:0]                i_wr_data,
  input  logic                             i_wr_dirty,
  input  logic                             i_lru_we,
  input  logic                             i_lru_val,
  input  logic                             i_clr_valid
);

  logic [TAG_W-1:0]    r_tag   [NUM_WAYS][SETS];
  logic [DATA_W-1:0]   r_data  [NUM_WAYS][SETS];
  logic [NUM_WAYS-1:0] r_valid [SETS];
  logic [NUM_WAYS-1:0] r_dirty [SETS];
  logic [SETS-1:0]     r_lru;

  // Tag/data need no reset: valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_way][i_wr_idx]  <= i_wr_tag;
      r_data[i_way][i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
      r_lru <= '0;
    end else begin
      if (i_we) begin
        r_valid[i_wr_idx][i_way] <= 1'b1;
        r_dirty[i_wr_idx][i_way] <= i_wr_dirty;
      end
      if (i_lru_we) r_lru[i_wr_idx] <= i_lru_val;
      // Global clear takes precedence over a same-cycle entry write.
      if (i_clr_valid) begin
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      o_tag[w]   = r_tag[w][i_rd_idx];
      o_data[w]  = r_data[w][i_rd_idx];
      o_valid[w] = r_valid[i_rd_idx][w];
      o_dirty[w] = r_dirty[i_rd_idx][w];
    end
    o_lru = r_lru[i_rd_idx];
  end

endmodule

// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb
// 2-way set-associative, write-back, write-allocate cache between the CPU
// request port and the AXI memory adapter. True LRU per set, entry-walking
// flush that writes back only dirty lines. One data word per line.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   src_valid/src_ready        : CPU request handshake (ready only in IDLE)
//   req_type, flush_req        : 0 read / 1 write; flush_req turns src_valid into a flush
//   cpu_addr, cpu_wdata        : byte address (bits [1:0] ignored), write data
//   cpu_rdata, resp_valid      : read data and one-cycle completion pulse
//   flush_done                 : one-cycle flush completion pulse
//   mem_rd_req/mem_araddr      : line fill request and address
//   mem_wr_req/mem_awaddr/mem_wdata : write-back request, address and data
//   mem_rdata, axi_ack         : fill data and one-cycle completion pulse
// Optional macro CACHE_PERF_CNT_EN adds hit_count/miss_count/wb_count outputs.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | ready for a request or flush command
// ST_COMPARE   | tag lookup; hit completes, miss picks a victim
// ST_WRITEBACK | writing dirty victim to memory
// ST_ALLOCATE  | fetching requested line into the victim way
// ST_FLUSH     | walking entries (set-major, way0 then way1), one per cycle
// ST_FLUSH_WB  | writing back the dirty entry the walk stopped on
module cache_assoc_wb
  import cache_assoc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              req_type,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              resp_valid,
  output logic              flush_done,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic [ADDR_W-1:0] mem_awaddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              axi_ack
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int FC_W  = IDX_W + 1;

  state_t              r_state;
  logic                r_type;
  logic [TAG_W-1:0]    r_tag;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_victim;
  logic [FC_W-1:0]     r_fcnt;
  logic                r_mem_rd_req;
  logic                r_mem_wr_req;
  logic [ADDR_W-1:0]   r_araddr;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_flush_done;

  logic [IDX_W-1:0]                w_lk_idx;
  logic [NUM_WAYS-1:0][TAG_W-1:0]  w_rd_tag;
  logic [NUM_WAYS-1:0][DATA_W-1:0] w_rd_data;
  logic [NUM_WAYS-1:0]             w_rd_valid;
  logic [NUM_WAYS-1:0]             w_rd_dirty;
  logic                            w_rd_lru;
  logic                            w_hit0, w_hit1, w_hit, w_hit_way;
  logic                            w_victim, w_victim_dirty;
  logic                            w_fway, w_fdirty, w_flast;
  logic [IDX_W-1:0]                w_fset;
  logic                            w_we, w_way, w_wr_dirty;
  logic [IDX_W-1:0]                w_wr_idx;
  logic [TAG_W-1:0]                w_wr_tag;
  logic [DATA_W-1:0]               w_wr_data;
  logic                            w_lru_we, w_lru_val, w_clr_valid;
  logic                            w_unused;

  assign w_unused = &{1'b0, cpu_addr[1:0]};

  assign w_fway   = r_fcnt[0];
  assign w_fset   = r_fcnt[FC_W-1:1];
  assign w_flast  = &r_fcnt;
  assign w_lk_idx = (r_state == ST_FLUSH || r_state == ST_FLUSH_WB) ? w_fset : r_idx;

  cache_assoc_array #(
    .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (w_lk_idx),
    .o_tag      (w_rd_tag),
    .o_data     (w_rd_data),
    .o_valid    (w_rd_valid),
    .o_dirty    (w_rd_dirty),
    .o_lru      (w_rd_lru),
    .i_we       (w_we),
    .i_way      (w_way),
    .i_wr_idx   (w_wr_idx),
    .i_wr_tag   (w_wr_tag),
    .i_wr_data  (w_wr_data),
    .i_wr_dirty (w_wr_dirty),
    .i_lru_we   (w_lru_we),
    .i_lru_val  (w_lru_val),
    .i_clr_valid(w_clr_valid)
  );

  assign w_hit0         = w_rd_valid[0] && (w_rd_tag[0] == r_tag);
  assign w_hit1         = w_rd_valid[1] && (w_rd_tag[1] == r_tag);
  assign w_hit          = w_hit0 || w_hit1;
  assign w_hit_way      = w_hit1;
  assign w_victim       = pick_victim(w_rd_valid[0], w_rd_valid[1], w_rd_lru);
  assign w_victim_dirty = w_rd_valid[w_victim] && w_rd_dirty[w_victim];
  assign w_fdirty       = w_rd_valid[w_fway] && w_rd_dirty[w_fway];

  always_comb begin
    w_we        = 1'b0;
    w_way       = 1'b0;
    w_wr_idx    = r_idx;
    w_wr_tag    = r_tag;
    w_wr_data   = r_wdata;
    w_wr_dirty  = 1'b0;
    w_lru_we    = 1'b0;
    w_lru_val   = 1'b0;
    w_clr_valid = 1'b0;
    case (r_state)
      ST_COMPARE: begin
        if (w_hit) begin
          w_lru_we  = 1'b1;
          w_lru_val = ~w_hit_way;
          if (r_type == REQ_WRITE) begin
            w_we       = 1'b1;
            w_way      = w_hit_way;
            w_wr_dirty = 1'b1;
          end
        end
      end
      ST_ALLOCATE: begin
        if (axi_ack) begin
          w_we      = 1'b1;
          w_way     = r_victim;
          w_wr_data = mem_rdata;
        end
      end
      ST_FLUSH: w_clr_valid = !w_fdirty && w_flast;
      ST_FLUSH_WB: begin
        if (axi_ack) begin
          // Rewrite the entry unchanged except for the dirty bit.
          w_we        = 1'b1;
          w_way       = w_fway;
          w_wr_idx    = w_fset;
          w_wr_tag    = w_rd_tag[w_fway];
          w_wr_data   = w_rd_data[w_fway];
          w_clr_valid = w_flast;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_type       <= REQ_READ;
      r_tag        <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_victim     <= 1'b0;
      r_fcnt       <= '0;
      r_mem_rd_req <= 1'b0;
      r_mem_wr_req <= 1'b0;
      r_araddr     <= '0;
      r_awaddr     <= '0;
      r_mem_wdata  <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (src_valid) begin
            if (flush_req) begin
              r_fcnt  <= '0;
              r_state <= ST_FLUSH;
            end else begin
              r_type  <= req_type;
              r_tag   <= cpu_addr[ADDR_W-1:IDX_W+2];
              r_idx   <= cpu_addr[IDX_W+1:2];
              r_wdata <= cpu_wdata;
              r_state <= ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          if (w_hit) begin
            r_state <= ST_IDLE;
          end else begin
            r_victim <= w_victim;
            if (w_victim_dirty) begin
              r_mem_wr_req <= 1'b1;
              r_awaddr     <= {w_rd_tag[w_victim], r_idx, 2'b00};
              r_mem_wdata  <= w_rd_data[w_victim];
              r_state      <= ST_WRITEBACK;
            end else begin
              r_mem_rd_req <= 1'b1;
              r_araddr     <= {r_tag, r_idx, 2'b00};
              r_state      <= ST_ALLOCATE;
            end
          end
        end
        ST_WRITEBACK: begin
          if (axi_ack) begin
            r_mem_wr_req <= 1'b0;
            r_mem_rd_req <= 1'b1;
            r_araddr     <= {r_tag, r_idx, 2'b00};
            r_state      <= ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          // Next COMPARE hits by construction and merges a pending write.
          if (axi_ack) begin
            r_mem_rd_req <= 1'b0;
            r_state      <= ST_COMPARE;
          end
        end
        ST_FLUSH: begin
          if (w_fdirty) begin
            r_mem_wr_req <= 1'b1;
            r_awaddr     <= {w_rd_tag[w_fway], w_fset, 2'b00};
            r_mem_wdata  <= w_rd_data[w_fway];
            r_state      <= ST_FLUSH_WB;
          end else if (w_flast) begin
            r_fcnt       <= '0;
            r_flush_done <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_fcnt <= r_fcnt + FC_W'(1);
          end
        end
        ST_FLUSH_WB: begin
          if (axi_ack) begin
            r_mem_wr_req <= 1'b0;
            if (w_flast) begin
              r_fcnt       <= '0;
              r_flush_done <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_fcnt  <= r_fcnt + FC_W'(1);
              r_state <= ST_FLUSH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Response is combinational from the lookup so a hit completes the cycle
  // after the handshake.
  assign src_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_COMPARE) && w_hit;
  assign cpu_rdata  = (resp_valid && r_type == REQ_READ) ? w_rd_data[w_hit_way] : '0;
  assign flush_done = r_flush_done;
  assign mem_rd_req = r_mem_rd_req;
  assign mem_wr_req = r_mem_wr_req;
  assign mem_araddr = r_mem_rd_req ? r_araddr : '0;
  assign mem_awaddr = r_mem_wr_req ? r_awaddr : '0;
  assign mem_wdata  = r_mem_wr_req ? r_mem_wdata : '0;

`ifdef CACHE_PERF_CNT_EN
  // r_first marks the COMPARE that directly follows a handshake; the
  // post-fill COMPARE is not counted again.
  logic r_first;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_first    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (r_state == ST_IDLE) r_first <= src_valid && !flush_req;
      else if (r_state == ST_COMPARE) r_first <= 1'b0;
      if (r_state == ST_COMPARE && r_first) begin
        if (w_hit) hit_count  <= hit_count + 32'd1;
        else       miss_count <= miss_count + 32'd1;
      end
      if (axi_ack && (r_state == ST_WRITEBACK || r_state == ST_FLUSH_WB))
        wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cache_assoc_wb.md
# cache_assoc_wb

Parametrised 2-way set-associative, write-back, write-allocate cache sitting between the CPU request port and the AXI memory adapter; the successor to the current direct-mapped controller/datapath pair. It adds configurable set count and widths, true-LRU replacement per set, and an entry-walking flush that writes back only dirty lines. Each line holds one data word.

## Interface
- ADDR_W, 32, CPU/memory address width
- DATA_W, 32, word width
- SETS, 16, number of sets; power of two, ≥2; IDX_W = $clog2(SETS), TAG_W = ADDR_W-IDX_W-2
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- src_valid  in  1  CPU request valid
- src_ready  out  1  block idle and able to accept a request
- req_type  in  1  0 = read, 1 = write
- flush_req  in  1  qualifies src_valid as a flush command
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while resp_valid
- resp_valid  out  1  one-cycle pulse: read/write completed
- flush_done  out  1  one-cycle pulse: flush completed
- mem_rd_req / mem_wr_req  out  1  memory read/write request
- mem_araddr / mem_awaddr  out  ADDR_W  line address, bits [1:0] = 0
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  fill data, sampled on axi_ack
- axi_ack  in  1  one-cycle completion pulse for the outstanding request

## Operation
- Address split: index = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2].
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH, FLUSH_WB.
- IDLE: src_ready=1. src_valid&flush_req → FLUSH (flush wins). src_valid&!flush_req → latch addr/wdata/type → COMPARE.
- COMPARE: hit on either valid way with matching tag. Read hit: cpu_rdata=way data, resp_valid=1. Write hit: store wdata, dirty=1, resp_valid=1. Either → IDLE; LRU[set] = other way.
- Miss victim: first invalid way (way0 before way1), else way LRU[set]. Victim valid&dirty → WRITEBACK, else → ALLOCATE.
- WRITEBACK: mem_wr_req=1, awaddr={victim tag,index,2'b00}, wdata = victim data; on axi_ack → ALLOCATE.
- ALLOCATE: mem_rd_req=1, araddr={tag,index,2'b00}; on axi_ack write mem_rdata to victim, valid=1, dirty=0, new tag → COMPARE (guaranteed hit; write miss merges there).
- FLUSH: counter walks 2*SETS entries (set-major, way0 then way1). Dirty entry → FLUSH_WB; on ack clear dirty, advance. After last entry: clear all valid bits, flush_done=1, → IDLE.
- axi_ack outside WRITEBACK/ALLOCATE/FLUSH_WB ignored. src_valid ignored while src_ready=0.
- Memory outputs are 0 whenever their request is low; cpu_rdata is 0 outside resp_valid.

## Timing
- Reset: state IDLE, all valid/dirty/LRU bits 0; src_ready=1; all other outputs 0.
- Reset mid-transaction: requests drop on the next edge; dirty data is discarded, not written back.
- Hit latency: handshake at cycle N, resp_valid at N+1.
- Clean miss: COMPARE N+1, ALLOCATE from N+2 until ack cycle A, resp_valid at A+1.
- Requests assert on state entry, remain high through the ack cycle inclusive, and drop the cycle after.
- Ack in the first request cycle is legal.
- Flush of clean cache: 2*SETS cycles in FLUSH, then flush_done.

## Configuration
- CACHE_PERF_CNT_EN defined: adds output ports hit_count, miss_count, wb_count (32-bit each, wrap on overflow, reset 0).
- hit/miss counted once per request at the first COMPARE only; the post-fill COMPARE does not count.
- wb_count increments on every write-back ack, including flush write-backs.
- Undefined: ports and counters absent; all other behaviour is identical.

## Structure
- Package cache_assoc_pkg: state enum, REQ_READ/REQ_WRITE localparams, NUM_WAYS=2.
- Sub-module cache_assoc_array: tag/data/valid/dirty/LRU storage.
  - Provides combinational two-way lookup, one write port and a global valid clear.
  - The FSM and flush counter stay in the top.

## Test plan
- SETS=16, read 0x040 → mem_rd_req with araddr 0x040; ack with 0xDEADBEEF → resp_valid with rdata 0xDEADBEEF. Re-read → resp_valid 1 cycle after handshake, no memory request.
- Write 0x040=0x11 (hit, dirty); read 0x440, then 0x840 → mem_wr_req awaddr 0x040 wdata 0x11, then mem_rd_req 0x840.
- LRU: read A=0x040, B=0x440, A, then C=0x840 → B evicted (clean, no write-back); a subsequent read of A hits.
- Write miss 0x080=0x55 → fill, merged write; read 0x080 returns 0x55 with no memory traffic.
- Three dirty lines, flush → exactly three mem_wr_req with correct addresses, flush_done pulse, next read of each address misses.
- Reset during ALLOCATE → mem_rd_req 0 next cycle, src_ready 1, prior hit address now misses. With CACHE_PERF_CNT_EN, a scripted 4 hits/3 misses/1 write-back gives counters 4/3/1.
